// File: rtl/tree_pkg.sv
// Shared types and constants for the tree serializer/deserializer pair.
// Holds the alignment FSM states, default widths/sync word and a counter-width helper.
package tree_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } deser_state_e;

    localparam int TREE_FROM    = 16;
    localparam int TREE_LOGFROM = 4;

    localparam logic [15:0] TREE_SYNC_WORD = 16'hA5C3;

    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// Serial-to-parallel shift register plus word-phase counter; candidate word is combinational.
// No backpressure: shifts every clk, load_zero restarts the word phase on the next cycle.
module deser_shift_reg #(
    parameter int TO    = 16,
    parameter int LOGTO = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          serial_bit,
    input  logic          load_zero,
    output logic [TO-1:0] candidate,
    output logic          word_end
);

    logic [TO-1:0]    sr;
    logic [LOGTO-1:0] bit_cnt;

    // Newest bit enters at the MSB so the first bit of a word ends up at bit 0.
    assign candidate = {serial_bit, sr[TO-1:1]};
    assign word_end  = (bit_cnt == LOGTO'(TO - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr      <= candidate;
            bit_cnt <= load_zero ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tree_deserializer.sv
// Rebuilds TO-bit words from a serial stream with sync-word hunt/confirm/locked alignment.
// Word and valid strobe appear one cycle after the word's last bit; no backpressure.
module tree_deserializer
    import tree_pkg::*;
#(
    parameter int            TO         = TREE_FROM,
    parameter int            LOGTO      = TREE_LOGFROM,
    parameter logic [TO-1:0] SYNC_WORD  = TO'(TREE_SYNC_WORD),
    parameter int            SYNC_HITS  = 2,
    parameter int            LOSS_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_i,
    input  logic          sync_slot_i,
    input  logic          realign_i,
    output logic [TO-1:0] data_o,
    output logic          valid_o,
    output logic          lock_o,
    output logic          err_o
);

    localparam int CNT_W = cnt_width(7);
    localparam logic [CNT_W-1:0] HITS_MAX = CNT_W'(SYNC_HITS);
    localparam logic [CNT_W-1:0] LOSS_MAX = CNT_W'(LOSS_LIMIT);

    deser_state_e     state_q, state_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [CNT_W-1:0] misses_q, misses_d;
    logic [TO-1:0]    candidate;
    logic             word_end;
    logic             load_zero;
    logic             sync_match;
    logic             valid_d, err_d, lock_d;

    deser_shift_reg #(
        .TO    (TO),
        .LOGTO (LOGTO)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .serial_bit (data_i),
        .load_zero  (load_zero),
        .candidate  (candidate),
        .word_end   (word_end)
    );

    assign sync_match = (candidate == SYNC_WORD);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= HUNT;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            state_q  <= state_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hits_d    = hits_q;
        misses_d  = misses_q;
        load_zero = 1'b0;
        if (realign_i) begin
            state_d  = HUNT;
            hits_d   = '0;
            misses_d = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    // Sliding compare: a hit defines the word phase from the next cycle on.
                    if (sync_match) begin
                        load_zero = 1'b1;
                        hits_d    = CNT_W'(1);
                        state_d   = (SYNC_HITS == 1) ? LOCKED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (word_end) begin
                        if (sync_match) begin
                            hits_d = hits_q + 1'b1;
                            if (hits_q + 1'b1 == HITS_MAX) state_d = LOCKED;
                        end else begin
                            hits_d  = '0;
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (word_end && sync_slot_i) begin
                        if (sync_match) begin
                            misses_d = '0;
                        end else if (misses_q + 1'b1 == LOSS_MAX) begin
                            state_d  = HUNT;
                            hits_d   = '0;
                            misses_d = '0;
                        end else begin
                            misses_d = misses_q + 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        valid_d = 1'b0;
        err_d   = 1'b0;
        // The word that triggers loss of lock is still delivered.
        if (state_q == LOCKED && word_end && !realign_i) begin
            valid_d = 1'b1;
            err_d   = sync_slot_i && !sync_match;
        end
        lock_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            lock_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            valid_o <= valid_d;
            lock_o  <= lock_d;
            err_o   <= err_d;
            if (valid_d) data_o <= candidate;
        end
    end

endmodule

// File: tb/tb_tree_deserializer.sv
// Directed bench for tree_deserializer (TO=8, sync 8'hA5, 2 hits to lock, 2 misses to lose).
module tb_tree_deserializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       data_i = 1'b0;
    logic       sync_slot_i = 1'b0;
    logic       realign_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       lock_o;
    logic       err_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tree_deserializer #(
        .TO         (8),
        .LOGTO      (3),
        .SYNC_WORD  (8'hA5),
        .SYNC_HITS  (2),
        .LOSS_LIMIT (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_i      (data_i),
        .sync_slot_i (sync_slot_i),
        .realign_i   (realign_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .lock_o      (lock_o),
        .err_o       (err_o)
    );

    // One record per burst of bits (LSB first); expectations hold after its last bit's edge.
    typedef struct {
        int         nbits;
        logic [7:0] word;
        logic       slot;
        logic       rl;
        int         ev;
        logic [7:0] ed;
        int         ee;
        logic       el;
    } vec_t;

    vec_t vt[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, " lock"},  {31'd0, lock_o},  32'd0);
        check({tag, " err"},   {31'd0, err_o},   32'd0);
        check({tag, " data"},  {24'd0, data_o},  32'd0);
    endtask

    initial begin
        int vcnt;
        int ecnt;
        int vidx;

        //          nbits word   slot  rl    ev  ed     ee  el
        vt[0]  = '{3, 8'h06, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0};  // misaligned prefix 0,1,1
        vt[1]  = '{8, 8'hA5, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0};  // hunt hit -> confirm
        vt[2]  = '{8, 8'h5A, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0};  // confirm fails -> hunt
        vt[3]  = '{2, 8'h03, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0};  // shift to a new phase
        vt[4]  = '{8, 8'hA5, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0};
        vt[5]  = '{8, 8'hA5, 1'b0, 1'b0, 0, 8'h00, 0, 1'b1};  // lock rises
        vt[6]  = '{8, 8'h3C, 1'b0, 1'b0, 1, 8'h3C, 0, 1'b1};
        vt[7]  = '{8, 8'h00, 1'b1, 1'b0, 1, 8'h00, 1, 1'b1};  // bad sync slot 1
        vt[8]  = '{8, 8'hFF, 1'b1, 1'b0, 1, 8'hFF, 1, 1'b0};  // bad sync slot 2 -> loss
        vt[9]  = '{8, 8'hA5, 1'b0, 1'b0, 0, 8'hFF, 0, 1'b0};
        vt[10] = '{8, 8'hA5, 1'b0, 1'b0, 0, 8'hFF, 0, 1'b1};
        vt[11] = '{8, 8'h12, 1'b0, 1'b0, 1, 8'h12, 0, 1'b1};
        vt[12] = '{8, 8'hA5, 1'b1, 1'b0, 1, 8'hA5, 0, 1'b1};  // good sync slot as data
        vt[13] = '{8, 8'h77, 1'b0, 1'b1, 0, 8'hA5, 0, 1'b0};  // realign at boundary
        vt[14] = '{8, 8'hA5, 1'b0, 1'b0, 0, 8'hA5, 0, 1'b0};
        vt[15] = '{8, 8'hA5, 1'b0, 1'b0, 0, 8'hA5, 0, 1'b1};
        vt[16] = '{8, 8'h9C, 1'b0, 1'b0, 1, 8'h9C, 0, 1'b1};

        // Reset held low with random data on the line.
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            data_i = 1'($urandom_range(0, 1));
            tick();
            check_idle($sformatf("reset%0d", c));
        end
        reset = 1'b1;

        for (int r = 0; r < 17; r++) begin
            vcnt = 0;
            ecnt = 0;
            vidx = -1;
            for (int i = 0; i < vt[r].nbits; i++) begin
                data_i      = vt[r].word[i];
                sync_slot_i = vt[r].slot;
                realign_i   = vt[r].rl && (i == vt[r].nbits - 1);
                tick();
                if (valid_o === 1'b1) begin
                    vcnt++;
                    vidx = i;
                end
                if (err_o === 1'b1) ecnt++;
            end
            realign_i   = 1'b0;
            sync_slot_i = 1'b0;
            check($sformatf("vec%0d valid_count", r), vcnt, vt[r].ev);
            check($sformatf("vec%0d err_count", r), ecnt, vt[r].ee);
            check($sformatf("vec%0d lock", r), {31'd0, lock_o}, {31'd0, vt[r].el});
            check($sformatf("vec%0d data", r), {24'd0, data_o}, {24'd0, vt[r].ed});
            if (vt[r].ev > 0)
                check($sformatf("vec%0d valid_pos", r), vidx, vt[r].nbits - 1);
        end

        // Mid-word reset while locked: half of 8'hF0, then reset, then the rest.
        for (int i = 0; i < 4; i++) begin
            data_i = 1'b0;
            tick();
        end
        check("midword locked", {31'd0, lock_o}, 32'd1);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            data_i = 1'($urandom_range(0, 1));
            tick();
            check_idle($sformatf("midreset%0d", c));
        end
        reset = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            data_i = (i < 4) ? 1'b1 : 1'b0;
            tick();
            if (valid_o === 1'b1) vcnt++;
        end
        check("post_reset valid_count", vcnt, 0);
        check_idle("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
